// File: rtl/evt_timestamp_fifo.sv
// -----------------------------------------------------------------------------
// evt_timestamp_fifo
//   Stamps each granted arbiter event with a free-running cycle timestamp.
//   Tags the first event of each arbitration group.
//   Buffers the stamped words in a first-word-fall-through synchronous FIFO.
//   Events arriving while the FIFO is full are dropped (and optionally counted).
//
// Ports
//   clk_i          : clock, rising edge
//   reset_i        : synchronous active-high reset
//   evt_valid_i    : event present this cycle
//   evt_data_i     : event word [WIDTH]
//   grp_release_i  : arbitration group release
//   out_valid_o    : head word available
//   out_ready_i    : consumer accepts head word
//   out_data_o     : head word {timestamp, event data}, zero when not valid
//   out_first_o    : head word is first of its group, zero when not valid
//   full_o         : FIFO holds DEPTH entries
//   almost_full_o  : occupancy >= AF_LEVEL
//   level_o        : occupancy
//   drop_cnt_o     : dropped-event count
//
// Configuration macro
//   EVT_DROP_CNT_EN : when defined, drop_cnt_o is a saturating 16-bit counter;
//                     otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module evt_timestamp_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TS_WIDTH = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          evt_valid_i,
    input  logic [WIDTH-1:0]              evt_data_i,
    input  logic                          grp_release_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [TS_WIDTH+WIDTH-1:0]     out_data_o,
    output logic                          out_first_o,
    output logic                          full_o,
    output logic                          almost_full_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = TS_WIDTH + WIDTH;
    localparam int unsigned EW = DW + 1;

    // Storage entry layout: {first, timestamp, data}
    logic [EW-1:0]       r_mem [DEPTH];

    logic [TS_WIDTH-1:0] r_ts;
    logic                r_pend_first;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [PW-1:0]       r_level;
    logic                r_valid;
    logic                r_full;
    logic                r_afull;

    logic                w_push;
    logic                w_pop;
    logic [PW-1:0]       w_wptr_nxt;
    logic [PW-1:0]       w_rptr_nxt;
    logic [PW-1:0]       w_level_nxt;
    logic [EW-1:0]       w_head;

    // Full is judged on start-of-cycle state, so a same-cycle pop never frees a slot
    assign w_push      = evt_valid_i & ~r_full;
    assign w_pop       = r_valid & out_ready_i;
    assign w_wptr_nxt  = r_wptr + PW'(w_push);
    assign w_rptr_nxt  = r_rptr + PW'(w_pop);
    assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

    // Timestamp counter; wraps naturally at 2^TS_WIDTH
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // Group-first flag: release wins over an accepted event; drops leave it alone
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pend_first <= 1'b1;
        end else if (grp_release_i) begin
            r_pend_first <= 1'b1;
        end else if (w_push) begin
            r_pend_first <= 1'b0;
        end
    end

    // Entry storage, not reset: contents are only visible through valid pointers
    always_ff @(posedge clk_i) begin
        if (w_push && !reset_i) begin
            r_mem[r_wptr[AW-1:0]] <= {r_pend_first, r_ts, evt_data_i};
        end
    end

    // Pointers and registered status flags, all from next-state occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
            r_full  <= (w_level_nxt == PW'(DEPTH));
            r_afull <= (w_level_nxt >= PW'(AF_LEVEL));
        end
    end

`ifdef EVT_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = evt_valid_i & r_full;

    // Saturating drop counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 16'd0;
`endif

    // Head word, zero-gated when the FIFO is empty
    assign w_head        = r_mem[r_rptr[AW-1:0]];
    assign out_valid_o   = r_valid;
    assign out_data_o    = r_valid ? w_head[DW-1:0] : '0;
    assign out_first_o   = r_valid & w_head[EW-1];
    assign full_o        = r_full;
    assign almost_full_o = r_afull;
    assign level_o       = r_level;

endmodule

// File: tb/tb_evt_timestamp_fifo.sv
// Bench for evt_timestamp_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal checks on the directed scenarios.
module tb_evt_timestamp_fifo;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 12;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        evt_valid_i;
    logic [7:0]  evt_data_i;
    logic        grp_release_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [23:0] out_data_o;
    logic        out_first_o;
    logic        full_o;
    logic        almost_full_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    evt_timestamp_fifo #(
        .WIDTH(8), .TS_WIDTH(16), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .evt_valid_i(evt_valid_i),
        .evt_data_i(evt_data_i), .grp_release_i(grp_release_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_first_o(out_first_o),
        .full_o(full_o), .almost_full_o(almost_full_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_drops(input int n);
`ifdef EVT_DROP_CNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] ts;
        logic [7:0]  d;
        logic        f;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_ts;
    logic        m_pend;
    int          m_drops;
    bit          m_live = 0;

    always @(posedge clk) begin
        if (reset_i) begin
            m_q.delete();
            m_ts    = 16'd0;
            m_pend  = 1'b1;
            m_drops = 0;
            m_live  = 1;
        end else if (m_live) begin
            bit was_full;
            bit do_pop;
            ent_t e;
            was_full = (m_q.size() == DEPTH);
            do_pop   = (m_q.size() > 0) && out_ready_i;
            if (do_pop) void'(m_q.pop_front());
            if (evt_valid_i) begin
                if (!was_full) begin
                    e.ts = m_ts; e.d = evt_data_i; e.f = m_pend;
                    m_q.push_back(e);
                    m_pend = 1'b0;
                end else begin
`ifdef EVT_DROP_CNT_EN
                    if (m_drops < 65535) m_drops++;
`endif
                end
            end
            if (grp_release_i) m_pend = 1'b1;
            m_ts = m_ts + 16'd1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit saw_ffff = 0;
    bit saw_wrap = 0;

    always @(negedge clk) begin
        if (m_live) begin
            int sz;
            sz = m_q.size();
            chk("valid", 32'(out_valid_o), 32'(sz > 0));
            chk("data",  32'(out_data_o),  (sz > 0) ? 32'({m_q[0].ts, m_q[0].d}) : 32'd0);
            chk("first", 32'(out_first_o), (sz > 0) ? 32'(m_q[0].f) : 32'd0);
            chk("level", 32'(level_o),     32'(sz));
            chk("full",  32'(full_o),      32'(sz == DEPTH));
            chk("afull", 32'(almost_full_o), 32'(sz >= AF_LEVEL));
            chk("drops", 32'(drop_cnt_o),  32'(m_drops));
            if (out_valid_o && out_data_o[23:8] == 16'hFFFF) saw_ffff = 1;
            else if (saw_ffff && out_valid_o && out_data_o[23:8] == 16'h0000) saw_wrap = 1;
        end
    end

    // One cycle of stimulus; returns #1 after the consuming edge
    task automatic drive(input logic v, input logic [7:0] d, input logic g, input logic r);
        evt_valid_i   = v;
        evt_data_i    = d;
        grp_release_i = g;
        out_ready_i   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data",  32'(out_data_o),  32'd0);
        chk("rst_level", 32'(level_o),     32'd0);
        chk("rst_full",  32'(full_o),      32'd0);
        chk("rst_drop",  32'(drop_cnt_o),  32'd0);

        // Scenario 1: first word after 5 idle cycles carries ts=5
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 0, 1);
        drive(1, 8'h2A, 0, 1);
        chk("s1_valid", 32'(out_valid_o), 32'd1);
        chk("s1_data",  32'(out_data_o),  32'h0005_2A);
        chk("s1_first", 32'(out_first_o), 32'd1);
        drive(0, 8'h00, 0, 1);
        chk("s1_level", 32'(level_o), 32'd0);

        // Scenario 2: group tagging and ordering
        drive(0, 8'h00, 1, 0);
        drive(1, 8'hA1, 0, 0);
        drive(1, 8'hB2, 0, 0);
        drive(1, 8'hC3, 0, 0);
        chk("s2_level", 32'(level_o), 32'd3);
        chk("s2_headA", 32'(out_data_o[7:0]), 32'hA1);
        chk("s2_firstA", 32'(out_first_o), 32'd1);
        drive(0, 8'h00, 0, 1);
        chk("s2_headB", 32'(out_data_o[7:0]), 32'hB2);
        chk("s2_firstB", 32'(out_first_o), 32'd0);
        drive(0, 8'h00, 0, 1);
        chk("s2_headC", 32'(out_data_o[7:0]), 32'hC3);
        chk("s2_firstC", 32'(out_first_o), 32'd0);
        drive(0, 8'h00, 0, 1);
        chk("s2_empty", 32'(out_valid_o), 32'd0);
        drive(0, 8'h00, 1, 0);
        drive(1, 8'hD4, 0, 0);
        chk("s2_headD", 32'(out_data_o[7:0]), 32'hD4);
        chk("s2_firstD", 32'(out_first_o), 32'd1);
        drive(0, 8'h00, 0, 1);

        // Scenario 3: overfill with consumer stalled
        for (int i = 1; i <= 18; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            chk("s3_afull", 32'(almost_full_o), 32'(i >= 12));
        end
        chk("s3_full",  32'(full_o),     32'd1);
        chk("s3_level", 32'(level_o),    32'd16);
        chk("s3_drop",  32'(drop_cnt_o), 32'(exp_drops(2)));

        // Scenario 4: push + pop while full; the push is still dropped
        drive(1, 8'hEE, 0, 1);
        chk("s4_level", 32'(level_o),    32'd15);
        chk("s4_full",  32'(full_o),     32'd0);
        chk("s4_drop",  32'(drop_cnt_o), 32'(exp_drops(3)));
        for (int i = 0; i < 16; i++) drive(0, 8'h00, 0, 1);
        chk("s4_drain", 32'(level_o), 32'd0);

        // Scenario 5: streaming through a timestamp wrap
        reset_i = 1'b1;
        drive(0, 8'h00, 0, 1);
        reset_i = 1'b0;
        for (int i = 0; i < 70000; i++) drive(1, 8'(i), 0, 1);
        chk("s5_level", 32'(level_o),    32'd1);
        chk("s5_drop",  32'(drop_cnt_o), 32'd0);
        chk("s5_wrap",  32'(saw_wrap),   32'd1);
        drive(0, 8'h00, 0, 1);

        // Scenario 6: reset flushes stored words
        for (int i = 0; i < 7; i++) drive(1, 8'(8'h70 + i), 0, 0);
        chk("s6_level7", 32'(level_o), 32'd7);
        reset_i = 1'b1;
        drive(1, 8'h99, 0, 1);
        chk("s6_valid", 32'(out_valid_o), 32'd0);
        chk("s6_level", 32'(level_o),     32'd0);
        chk("s6_drop",  32'(drop_cnt_o),  32'd0);
        reset_i = 1'b0;
        drive(1, 8'h55, 0, 0);
        chk("s6_data",  32'(out_data_o),  32'h0000_55);
        chk("s6_first", 32'(out_first_o), 32'd1);
        drive(0, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
